cache_fill_arbiter: RTL

Arbitrates the single shared `memory4c` main-memory port between the I-cache and D-cache and sequences every transfer on it. It handles 8-word block fills on cache misses and single-word D-cache write-through stores. It sits between the two `CACHE` instances and `MAIN_MEM` inside `cpu`, and replaces the ad-hoc fetch gating there.

---
 rtl/cache_fill_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cache_fill_arbiter.sv
// Shares the single main-memory port between the I-cache and D-cache. It runs
// pipelined block fills on misses and single-word D-cache write-through stores.
//
// state | meaning
// IDLE  | sample requests and grant; no memory activity
// WRITE | one-cycle write-through store, ack pulsed
// FILL  | issue one read per cycle, route each return to the owner's data array
// DONE  | one quiet cycle so a requester can drop its level request
module cache_fill_arbiter #(
    parameter int MEM_LATENCY     = 4,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    input  logic        d_write,
    input  logic [15:0] d_write_addr,
    input  logic [15:0] d_write_data,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_data_out,
    output logic        fill_i_we,
    output logic        fill_d_we,
    output logic [15:0] fill_addr,
    output logic [15:0] fill_data,
    output logic        i_fill_done,
    output logic        d_fill_done,
    output logic        d_write_ack,
    output logic        busy
);
    localparam int CW = $clog2(WORDS_PER_BLOCK);
    localparam logic [CW:0]   ISS_END  = (CW+1)'(WORDS_PER_BLOCK);
    localparam logic [CW:0]   ISS_ONE  = (CW+1)'(1);
    localparam logic [CW-1:0] RCV_LAST = CW'(WORDS_PER_BLOCK - 1);
    localparam logic [CW-1:0] RCV_ONE  = CW'(1);
    localparam logic [15:0]   BLK_MASK = ~16'(2 * WORDS_PER_BLOCK - 1);

    if (MEM_LATENCY < 1 || WORDS_PER_BLOCK < 2) begin : g_param_check
        $error("cache_fill_arbiter: unsupported MEM_LATENCY or WORDS_PER_BLOCK");
    end

    typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_t;

    state_t        state, next_state;
    logic [CW:0]   iss;
    logic [CW-1:0] rcv;
    logic          owner_d;
    logic          last_d;
    logic [15:0]   base;
    logic          grant_fill;
    logic          grant_d;
    logic          iss_end;
    logic          rcv_last;

    assign iss_end  = (iss == ISS_END);
    assign rcv_last = (rcv == RCV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        grant_fill = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (d_write) begin
                    next_state = WRITE;
                end else if (i_miss || d_miss) begin
                    next_state = FILL;
                    grant_fill = 1'b1;
                    // With both misses pending, the side not served last wins.
                    grant_d    = (i_miss && d_miss) ? !last_d : d_miss;
                end
            end
            WRITE:   next_state = DONE;
            FILL:    if (mem_data_valid && rcv_last) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss     <= '0;
            rcv     <= '0;
            owner_d <= 1'b0;
            last_d  <= 1'b0;
            base    <= '0;
        end else if (state == IDLE) begin
            iss <= '0;
            rcv <= '0;
            if (grant_fill) begin
                owner_d <= grant_d;
                last_d  <= grant_d;
                base    <= (grant_d ? d_miss_addr : i_miss_addr) & BLK_MASK;
            end
        end else if (state == FILL) begin
            if (!iss_end)       iss <= iss + ISS_ONE;
            if (mem_data_valid) rcv <= rcv + RCV_ONE;
        end
    end

    always_comb begin
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        fill_i_we   = 1'b0;
        fill_d_we   = 1'b0;
        fill_addr   = '0;
        fill_data   = '0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        d_write_ack = 1'b0;
        busy        = (state != IDLE);
        case (state)
            WRITE: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = d_write_addr;
                mem_data_in = d_write_data;
                d_write_ack = 1'b1;
            end
            FILL: begin
                if (!iss_end) begin
                    mem_enable = 1'b1;
                    mem_addr   = base + 16'({iss[CW-1:0], 1'b0});
                end
                if (mem_data_valid) begin
                    fill_i_we   = !owner_d;
                    fill_d_we   = owner_d;
                    fill_addr   = base + 16'({rcv, 1'b0});
                    fill_data   = mem_data_out;
                    i_fill_done = rcv_last && !owner_d;
                    d_fill_done = rcv_last && owner_d;
                end
            end
            default: ;
        endcase
    end
endmodule
